mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide unit with its own HI/LO registers.
//   Multiply: radix-2 Booth, one iteration per clock, WIDTH iterations.
//   Divide  : restoring divide on operand magnitudes, signs fixed on the last iteration.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   multControl           - start signed multiply (sampled in IDLE, wins over divide)
//   divControl            - start signed divide (sampled in IDLE)
//   a, b                  - operands, latched on the start edge
//   hi, lo                - product[2W-1:W]/product[W-1:0], or remainder/quotient
//   busy                  - operation in flight
//   done                  - one-cycle pulse when hi/lo hold a new result
//   divZero               - one-cycle pulse on divide by zero (exception build only)
// Build option: define MULTDIV_DIVZERO_EXCP_EN to raise divZero on divide by zero;
//   otherwise a divide by zero completes early with done and leaves hi/lo unchanged.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multControl,
    input  logic             divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    // accReg: Booth accumulator (one guard bit) or divide partial remainder
    // lowReg: Booth multiplier/product low half or divide dividend/quotient
    logic [WIDTH:0]   accReg;
    logic [WIDTH-1:0] lowReg;
    logic [WIDTH-1:0] opB;
    logic             qm1;
    logic             signA;
    logic             signB;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   mcandExt;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   boothAcc;
    logic [WIDTH-1:0] boothLow;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic             divGe;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] divQuo;
    logic [WIDTH-1:0] remFinal;
    logic [WIDTH-1:0] quotFinal;

    // Datapath for one Booth step and one restoring-divide step
    always_comb begin
        absA     = a[WIDTH-1] ? -a : a;
        absB     = b[WIDTH-1] ? -b : b;
        // Guard bit keeps acc - (most negative multiplicand) from overflowing
        mcandExt = {opB[WIDTH-1], opB};
        case ({lowReg[0], qm1})
            2'b01:   boothSum = accReg + mcandExt;
            2'b10:   boothSum = accReg - mcandExt;
            default: boothSum = accReg;
        endcase
        boothAcc  = {boothSum[WIDTH], boothSum[WIDTH:1]};
        boothLow  = {boothSum[0], lowReg[WIDTH-1:1]};

        divShift  = {accReg[WIDTH-1:0], lowReg[WIDTH-1]};
        divDiff   = divShift - {1'b0, opB};
        divGe     = divShift >= {1'b0, opB};
        divRem    = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
        divQuo    = {lowReg[WIDTH-2:0], divGe};
        // Quotient truncates toward zero; remainder follows the dividend sign
        quotFinal = (signA ^ signB) ? -divQuo : divQuo;
        remFinal  = signA ? -divRem : divRem;
    end

    // Control FSM, operand/iteration registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            accReg  <= '0;
            lowReg  <= '0;
            opB     <= '0;
            qm1     <= 1'b0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (multControl) begin
                        state  <= MULT;
                        busy   <= 1'b1;
                        count  <= '0;
                        accReg <= '0;
                        lowReg <= b;
                        opB    <= a;
                        qm1    <= 1'b0;
                    end else if (divControl) begin
                        state  <= DIV;
                        busy   <= 1'b1;
                        count  <= '0;
                        accReg <= '0;
                        lowReg <= absA;
                        opB    <= absB;
                        signA  <= a[WIDTH-1];
                        signB  <= b[WIDTH-1];
                    end
                end
                MULT: begin
                    accReg <= boothAcc;
                    lowReg <= boothLow;
                    qm1    <= lowReg[0];
                    count  <= count + CNT_W'(1);
                    if (count == LAST_COUNT) begin
                        hi    <= boothAcc[WIDTH-1:0];
                        lo    <= boothLow;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DIV: begin
                    if (count == '0 && opB == '0) begin
                        // Divide by zero resolves on the first iteration edge
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef MULTDIV_DIVZERO_EXCP_EN
                        divZero <= 1'b1;
`else
                        done    <= 1'b1;
`endif
                    end else begin
                        accReg <= {1'b0, divRem};
                        lowReg <= divQuo;
                        count  <= count + CNT_W'(1);
                        if (count == LAST_COUNT) begin
                            hi    <= remFinal;
                            lo    <= quotFinal;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        multControl;
    logic        divControl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divZero;

    int checkCount = 0;
    int failCount  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .multControl (multControl),
        .divControl  (divControl),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .divZero     (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive a start in the current low phase; returns at the negedge after E0
    task automatic startNow(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        multControl = m;
        divControl  = d;
        a           = av;
        b           = bv;
        @(posedge clk);
        @(negedge clk);
        multControl = 1'b0;
        divControl  = 1'b0;
    endtask

    task automatic startOp(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        startNow(m, d, av, bv);
    endtask

    // From the negedge after E0, count busy cycles until done (bounded);
    // pulseAt >= 0 raises divControl on that sample index for one cycle
    task automatic waitDone(input int pulseAt, output int cycles, output int doneCount);
        cycles    = 0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == pulseAt) begin
                divControl = 1'b1;
                a          = 32'd100;
                b          = 32'd7;
            end else if (i == pulseAt + 1) begin
                divControl = 1'b0;
            end
            if (busy) cycles++;
            if (done) begin
                doneCount++;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic now, input logic m, input logic d,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int cyc;
        int dn;
        if (now) startNow(m, d, av, bv);
        else     startOp(m, d, av, bv);
        waitDone(-10, cyc, dn);
        checkVal({tag, "_busy"}, 64'(cyc), 64'd32);
        checkVal({tag, "_done"}, 64'(dn), 64'd1);
        checkVal({tag, "_hi"}, 64'(hi), 64'(expHi));
        checkVal({tag, "_lo"}, 64'(lo), 64'(expLo));
    endtask

    initial begin
        int cyc;
        int dn;
        reset       = 1'b1;
        multControl = 1'b0;
        divControl  = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clk);
        checkVal("rst_hilo", {hi, lo}, 64'd0);
        checkVal("rst_flags", {61'd0, busy, done, divZero}, 64'd0);
        reset = 1'b0;

        // Multiply 7 x -3, then a back-to-back start sampled at E33
        runOp("mul7m3", 1'b0, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("mulb2b", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
        @(negedge clk);
        checkVal("b2b_doneLow", 64'(done), 64'd0);

        runOp("mulMin", 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
        @(negedge clk);
        checkVal("hold_after", {31'd0, done, hi}, 64'h4000_0000);

        runOp("divm7", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divMin", 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        runOp("divPre", 1'b0, 1'b0, 1'b1, 32'h0000_0671, 32'h30, 32'h11, 32'h22);

        // Divide by zero with hi/lo = 0x11/0x22
        startOp(1'b0, 1'b1, 32'd5, 32'd0);
        checkVal("dz_e0_flags", {61'd0, busy, done, divZero}, 64'b100);
        @(negedge clk);
`ifdef MULTDIV_DIVZERO_EXCP_EN
        checkVal("dz_e1_flags", {61'd0, busy, done, divZero}, 64'b001);
`else
        checkVal("dz_e1_flags", {61'd0, busy, done, divZero}, 64'b010);
`endif
        checkVal("dz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
        @(negedge clk);
        checkVal("dz_e2_flags", {61'd0, busy, done, divZero}, 64'b000);

        // Reset asserted at E10 of a multiply aborts immediately
        startOp(1'b1, 1'b0, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkVal("rstMid_hilo", {hi, lo}, 64'd0);
        checkVal("rstMid_flags", {61'd0, busy, done, divZero}, 64'b000);
        #1 reset = 1'b0;
        runOp("divAfterRst", 1'b0, 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

        // Both starts high: multiply wins; a divide pulse at E5 is ignored
        startOp(1'b1, 1'b1, 32'd3, 32'd5);
        waitDone(4, cyc, dn);
        checkVal("arb_busy", 64'(cyc), 64'd32);
        checkVal("arb_hilo", {hi, lo}, 64'd15);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        checkVal("arb_noSecond", 64'(dn), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
